// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the eight-digit 7-segment scanner.
//   - Segment constants are active-low, bit order {g,f,e,d,c,b,a}.
//   - seg_lookup() is the 0..9 decode table; every other code shows a dash.
//   - state_e is the scan FSM encoding used by seven_seg_scanner.
package seven_seg_scanner_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  function automatic logic [6:0] seg_lookup(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder (active-low cathodes).
//   i_bcd : 4-bit digit code; 10..15 are shown as a dash
//   o_seg : cathodes {g,f,e,d,c,b,a}, 0 = segment lit
module bcd_to_7seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = seg_lookup(i_bcd);
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes eight BCD digits onto a common-anode 8-digit display.
// Each digit slot is TICK_DIV cycles: BLANK_CYCLES dark (anti-ghosting),
// then the digit is driven. The digits are snapshotted once per frame so a
// frame never mixes old and new values. Optional leading-zero suppression.
//   ck          : clock
//   reset       : asynchronous active-low reset
//   en          : scan enable, 0 = display dark
//   d0..d7      : BCD digits, d0 least significant
//   an          : anode enables, active-low, an[i] selects digit i
//   seg         : cathodes, active-low, {g,f,e,d,c,b,a}
//   frame_start : one-cycle pulse when a new snapshot is taken
// All outputs are registered; nothing reaches them combinationally from
// the inputs.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int TICK_DIV     = 12500,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic [3:0] d7,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [3:0]    r_shadow [8];
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_fs;

  state_e        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic          w_load;
  logic [7:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_fs_nxt;
  logic [6:0]    w_dec;
  logic          w_upper_zero;
  logic          w_suppress;
  logic [7:0]    w_an_drive;
  logic [6:0]    w_seg_drive;

  bcd_to_7seg u_dec (
    .i_bcd (r_shadow[r_idx]),
    .o_seg (w_dec)
  );

  // Digit idx is a leading zero when it and every more-significant digit
  // are zero. Digit 0 is always shown so the display never goes fully dark.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if ((3'(j) >= r_idx) && (r_shadow[j] != 4'd0)) w_upper_zero = 1'b0;
    end
    w_suppress = (LZ_BLANK != 0) && (r_idx != 3'd0) && w_upper_zero;
    if (w_suppress) begin
      w_an_drive  = 8'hFF;
      w_seg_drive = SEG_BLANK;
    end else begin
      w_an_drive  = ~(8'b1 << r_idx);
      w_seg_drive = w_dec;
    end
  end

  // Next-state and registered-output values. Outputs follow the state being
  // entered, so they change on the same edge as r_state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_an_nxt    = 8'hFF;
    w_seg_nxt   = SEG_BLANK;
    w_fs_nxt    = 1'b0;
    if (!en) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
          w_fs_nxt    = 1'b1;
        end
        ST_BLANK: begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = ST_DRIVE;
            w_an_nxt    = w_an_drive;
            w_seg_nxt   = w_seg_drive;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 3'd1;
            // Leaving digit 7 starts a new frame: take a fresh snapshot.
            if (r_idx == 3'd7) begin
              w_load   = 1'b1;
              w_fs_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
            w_an_nxt  = w_an_drive;
            w_seg_nxt = w_seg_drive;
          end
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      for (int i = 0; i < 8; i++) r_shadow[i] <= 4'd0;
      r_an    <= 8'hFF;
      r_seg   <= SEG_BLANK;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_fs    <= w_fs_nxt;
      if (w_load) begin
        r_shadow[0] <= d0;
        r_shadow[1] <= d1;
        r_shadow[2] <= d2;
        r_shadow[3] <= d3;
        r_shadow[4] <= d4;
        r_shadow[5] <= d5;
        r_shadow[6] <= d6;
        r_shadow[7] <= d7;
      end
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seven_seg_scanner.sv
`timescale 1ns/100ps
module tb_seven_seg_scanner;

  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FRAME = 8 * TD;

  logic       ck = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [3:0] d [8];
  logic [7:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       fs_a, fs_b;

  int checks = 0;
  int failures = 0;

  // Reference model state: cycles since the enabling edge plus the frame
  // snapshot. Expected outputs are derived from slot/offset arithmetic.
  bit         run = 1'b0;
  int         k = 0;
  logic [3:0] snap [8];
  logic [7:0] exp_an_a, exp_an_b;
  logic [6:0] exp_seg_a, exp_seg_b;
  logic       exp_fs;

  always #1 ck = ~ck;

  seven_seg_scanner #(.TICK_DIV(TD), .BLANK_CYCLES(BC), .LZ_BLANK(1)) dut_lz (
    .ck(ck), .reset(reset), .en(en),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
    .an(an_a), .seg(seg_a), .frame_start(fs_a)
  );

  seven_seg_scanner #(.TICK_DIV(TD), .BLANK_CYCLES(BC), .LZ_BLANK(0)) dut_all (
    .ck(ck), .reset(reset), .en(en),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
    .an(an_b), .seg(seg_b), .frame_start(fs_b)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (v > 4'd9) return 7'h3F;
    return t[v];
  endfunction

  task automatic set_dark();
    exp_an_a = 8'hFF; exp_seg_a = 7'h7F;
    exp_an_b = 8'hFF; exp_seg_b = 7'h7F;
  endtask

  // Called right after each rising edge with the inputs that edge sampled.
  task automatic model_edge();
    int pos, slot, off;
    bit upper_zero;
    exp_fs = 1'b0;
    set_dark();
    if (!reset || !en) begin
      run = 1'b0;
      return;
    end
    if (!run) begin
      run = 1'b1;
      k = 0;
    end else begin
      k++;
    end
    pos  = k % FRAME;
    slot = pos / TD;
    off  = pos % TD;
    if (pos == 0) for (int i = 0; i < 8; i++) snap[i] = d[i];
    exp_fs = (pos == 0);
    if (off >= BC) begin
      upper_zero = 1'b1;
      for (int j = slot; j < 8; j++) if (snap[j] != 4'd0) upper_zero = 1'b0;
      exp_an_b  = ~(8'b1 << slot);
      exp_seg_b = ref_seg(snap[slot]);
      if (!(slot > 0 && upper_zero)) begin
        exp_an_a  = exp_an_b;
        exp_seg_a = exp_seg_b;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge ck);
      model_edge();
      @(negedge ck);
      check("an_lz", an_a, exp_an_a);
      check("seg_lz", {1'b0, seg_a}, {1'b0, exp_seg_a});
      check("fs_lz", {7'b0, fs_a}, {7'b0, exp_fs});
      check("an_all", an_b, exp_an_b);
      check("seg_all", {1'b0, seg_b}, {1'b0, exp_seg_b});
      check("fs_all", {7'b0, fs_b}, {7'b0, exp_fs});
    end
  endtask

  // Advance until the model sits at the given position inside a frame.
  task automatic run_to(input int target);
    int budget;
    budget = 0;
    while (!(run && (k % FRAME) == target) && budget < 3 * FRAME) begin
      cycles(1);
      budget++;
    end
    check("run_to_reached", {7'b0, run && (k % FRAME) == target}, 8'h01);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) d[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 8; i++) snap[i] = 4'd0;

    // 1. Reset held with enable high: everything dark.
    reset = 1'b0;
    en = 1'b1;
    @(negedge ck);
    cycles(5);

    // 2. Scan order with two non-zero low digits.
    d = '{4'd5, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    reset = 1'b1;
    cycles(2 * FRAME + 2);

    // 3. All zero: only digit 0 drives with suppression, all eight without.
    for (int i = 0; i < 8; i++) d[i] = 4'd0;
    cycles(2 * FRAME);

    // 4. Tearing: a mid-frame change stays hidden until the next frame.
    d = '{4'd3, 4'd9, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
    run_to(0);
    run_to(3 * TD + 3);
    d[0] = 4'd7;
    cycles(FRAME + TD);

    // 5. Disable mid-drive of slot 2, then re-enable.
    run_to(2 * TD + 4);
    en = 1'b0;
    cycles(4);
    en = 1'b1;
    cycles(3 * TD);

    // 6a. Invalid code shows a dash.
    d[0] = 4'hC;
    run_to(0);
    cycles(TD + 2);

    // 6b. Asynchronous reset between edges while driving slot 0.
    run_to(BC + 2);
    #0.3;
    reset = 1'b0;
    #0.2;
    check("async_an_lz", an_a, 8'hFF);
    check("async_seg_lz", {1'b0, seg_a}, 8'h7F);
    check("async_fs_lz", {7'b0, fs_a}, 8'h00);
    check("async_an_all", an_b, 8'hFF);
    check("async_seg_all", {1'b0, seg_b}, 8'h7F);
    cycles(3);
    reset = 1'b1;
    cycles(TD + 4);

    // Randomized traffic: digit changes, leading-zero patterns, enable flips.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0) d[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) begin
        int top;
        top = $urandom_range(0, 7);
        for (int i = top; i < 8; i++) d[i] = 4'd0;
      end
      if ($urandom_range(0, 149) == 0) en = ~en;
      cycles(1);
    end
    en = 1'b1;
    cycles(FRAME + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Downstream of the eight-digit button counter.
- Takes the counter's eight 4-bit BCD digits (seg0..seg7 there, d0..d7 here) and time-multiplexes them onto a common 8-digit 7-segment display.
- Drives active-low anode enables and segment cathodes.
- Adds inter-digit blanking against ghosting, per-frame snapshotting against tearing, and optional leading-zero suppression.

Parameters:
- TICK_DIV, 12500, clock cycles per digit slot; legal range >= 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; legal range 1 .. TICK_DIV-1.
- LZ_BLANK, 1, 1 = suppress leading zeros (digit 0 always shown); 0 = show all digits.

Ports:
- ck  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; 0 = display dark.
- d0..d7  in  4 each  BCD digits; d0 is least significant.
- an  out  8  anode enables, active-low; an[i] selects digit i.
- seg  out  7  cathodes, active-low, {g,f,e,d,c,b,a}.
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Reset: reset=0 forces state OFF, idx=0, cnt=0, shadow digits=0, an=8'hFF, seg=7'h7F, frame_start=0. Takes effect immediately, without a clock edge, including mid-slot.
- an, seg and frame_start are registers, updated on the same edge as state. No combinational path from d0..d7 or en to any output.
- FSM states and transitions:
  - OFF: an=FF, seg=7F.
    - If en=1: load shadow<=d0..d7, idx<=0, cnt<=0, frame_start<=1, go to BLANK.
  - BLANK: an=FF, seg=7F; cnt increments.
    - When cnt==BLANK_CYCLES-1: go to DRIVE.
  - DRIVE: an=~(8'b1<<idx), seg=decode(shadow[idx]); cnt increments.
    - When cnt==TICK_DIV-1: cnt<=0, idx<=idx+1 (wraps 7->0), go to BLANK.
    - On wrap 7->0: also reload shadow and pulse frame_start for that one cycle.
- Any state with en=0: go to OFF on the next edge; outputs dark from that edge. Re-enable always restarts at idx 0 with a fresh snapshot.
- Slot length is exactly TICK_DIV cycles: BLANK_CYCLES dark, then TICK_DIV-BLANK_CYCLES driven. Frame length is 8*TICK_DIV.
- Snapshot: d0..d7 are sampled only at frame_start. Changes mid-frame are invisible until the next frame.
- Leading-zero suppression (LZ_BLANK=1, idx>0): if shadow digits idx..7 are all 0, the DRIVE phase keeps an=FF and seg=7F. Slot timing is unchanged. Digit 0 is never suppressed.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Codes 10..15 show a dash: 3F (g only).
- cnt is sized $clog2(TICK_DIV); idx is 3 bits.
- frame_start is never high in two consecutive cycles.

Decomposition:
- Shared package holds:
  - the segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - the 0..9 decode table;
  - the FSM state encoding (OFF, BLANK, DRIVE).
- One combinational sub-module, bcd_to_7seg (4-bit in, 7-bit active-low out), instantiated once on shadow[idx]. This is the natural split.
- Prescaler, FSM, snapshot and leading-zero logic stay in seven_seg_scanner.

Test Plan:
All scenarios run with TICK_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1, clock period 2 ns.
1. Reset hold: reset=0, en=1, d0..d7 arbitrary -> an=FF, seg=7F, frame_start=0 throughout.
2. Scan order: d0=5, d1=1, rest 0; release reset.
   - Frame: frame_start=1 on first edge, then 2 dark cycles, then an=FE with seg=12 for 6 cycles.
   - Slot 1: 2 dark cycles, then an=FD with seg=79 for 6 cycles.
   - Slots 2..7: an=FF (suppressed); frame_start recurs every 64 cycles.
3. All zero: d0..d7=0 -> only slot 0 drives, an=FE with seg=40; all other slots dark. Repeat with LZ_BLANK=0 -> all eight slots drive seg=40.
4. Tearing: during slot 3 set d0=7 -> slot 0 of the current frame unaffected. After the next frame_start, slot 0 shows seg=78.
5. en=0 mid-DRIVE of slot 2 -> an=FF, seg=7F on the next edge. en=1 again -> frame_start pulses and scanning resumes at an=FE after 2 dark cycles.
6. Invalid codes and async reset:
   - d0=4'hC -> slot 0 shows seg=3F.
   - Assert reset between clock edges mid-DRIVE -> an=FF and seg=7F immediately, before the next clock edge.
